// File: rtl/cpu_bcd_decode.sv
// cpu_bcd_decode: sequential three-digit BCD-to-binary reader.
//
// Reads the hundreds, tens and ones bytes from base, base+1 and base+2. It
// then folds them into an 8-bit binary value and flags malformed input.
//
// Optional feature macro: CPU_BCD_DECODE_CHECK_EN
//   defined     -> invalid / overflow are computed from the digits
//   not defined -> invalid / overflow are tied to 0; value is silently
//                  truncated to acc[7:0]; timing is identical
//
// Handshake: start is a request pulse and is sampled only while the block
// is IDLE. A start seen in any other state is dropped, not queued. busy is
// high from the cycle after acceptance through the DONE cycle. done is a
// single-cycle pulse in that DONE cycle. value/invalid/overflow change only
// at the edge into DONE and then hold until the next result.
//
// Memory port: mem_rd is high for one cycle per byte. mem_rdata is taken
// exactly one cycle after the matching mem_rd cycle. mem_addr is 0
// whenever mem_rd is low.
//
// All outputs are registered. The next-state logic also computes their next
// values, so no input reaches an output combinationally.

module cpu_bcd_decode #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            value,
    output logic                  invalid,
    output logic                  overflow,
    output logic [2:0]            dbg_state
);

    // Sequencer states. IDLE must encode as 0 so that a reset state reads
    // as 0 on dbg_state.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_H  = 3'd1,
        S_RD_T  = 3'd2,
        S_RD_O  = 3'd3,
        S_CAP_O = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] base_q;

    // Horner accumulator. Each digit contributes at most 15, so the largest
    // reachable value is 1665, which fits in 11 bits without wrapping.
    logic [10:0]           acc_q;
    logic [10:0]           acc_step;

    logic                  mem_rd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic                  busy_d;
    logic                  done_d;

    assign accept    = (state_q == S_IDLE) && start;
    assign acc_step  = (acc_q * 11'd10) + {7'd0, mem_rdata[3:0]};
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the next values of the registered memory strobe and
    // address. When leaving IDLE, base_q has not been loaded yet, so the
    // first address comes straight from base_addr.
    always_comb begin
        state_d    = state_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RD_H;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = base_addr;
                end
            end
            S_RD_H: begin
                state_d    = S_RD_T;
                mem_rd_d   = 1'b1;
                mem_addr_d = base_q + ADDR_WIDTH'(1);
            end
            S_RD_T: begin
                state_d    = S_RD_O;
                mem_rd_d   = 1'b1;
                mem_addr_d = base_q + ADDR_WIDTH'(2);
            end
            S_RD_O: begin
                state_d = S_CAP_O;
            end
            S_CAP_O: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // busy and done follow the state being entered, so they are aligned
    // with that state once registered.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Registered handshake and memory-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_rd   <= mem_rd_d;
            mem_addr <= mem_addr_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Latch the base address when a request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
        end else if (accept) begin
            base_q <= base_addr;
        end
    end

    // Accumulate one digit per data cycle. The hundreds byte arrives in RD_T,
    // the tens byte in RD_O and the ones byte in CAP_O. Each request clears
    // acc first, so the hundreds step is just 0*10 + digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= '0;
        end else if ((state_q == S_RD_T) || (state_q == S_RD_O) ||
                     (state_q == S_CAP_O)) begin
            acc_q <= acc_step;
        end
    end

    // Publish the result at the edge into DONE. acc_step already includes
    // the ones digit at that edge. Reset clears the result; an aborted
    // request never reaches this update.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 8'd0;
        end else if (state_q == S_CAP_O) begin
            value <= acc_step[7:0];
        end
    end

`ifdef CPU_BCD_DECODE_CHECK_EN
    logic digit_bad;
    logic inv_q;

    // The whole byte is compared, so 0x10 is invalid even though its low
    // nibble is a legal digit.
    assign digit_bad = (mem_rdata > 8'd9);

    // Sticky malformed-digit flag for the hundreds and tens bytes. The
    // ones byte is folded in directly when the result is published.
    always_ff @(posedge clk) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= 1'b0;
        end else if ((state_q == S_RD_T) || (state_q == S_RD_O)) begin
            inv_q <= inv_q | digit_bad;
        end
    end

    // Flags update together with value and hold with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            invalid  <= 1'b0;
            overflow <= 1'b0;
        end else if (state_q == S_CAP_O) begin
            invalid  <= inv_q | digit_bad;
            overflow <= (acc_step > 11'd255);
        end
    end
`else
    // Without checking, only the low nibble of read data is consumed.
    logic rdata_hi_unused;

    assign rdata_hi_unused = ^mem_rdata[7:4];
    assign invalid         = 1'b0;
    assign overflow        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bcd_decode.sv
// tb_cpu_bcd_decode: directed, table-driven bench for cpu_bcd_decode.
// A small byte-wide memory model answers reads one cycle after mem_rd.

module tb_cpu_bcd_decode;

    localparam int AW = 12;

`ifdef CPU_BCD_DECODE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic          busy;
    logic          done;
    logic [7:0]    value;
    logic          invalid;
    logic          overflow;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    cpu_bcd_decode #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .value     (value),
        .invalid   (invalid),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // Memory model: data is valid in the cycle after the read strobe.
    logic [7:0] mem [4096];

    always @(posedge clk) begin
        mem_rdata <= mem_rd ? mem[mem_addr] : 8'h00;
    end

    // Count done pulses at the end of each cycle.
    int done_cnt = 0;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [AW-1:0] base;
        logic [7:0]    h;
        logic [7:0]    t;
        logic [7:0]    o;
        logic [7:0]    exp_value;
        logic          exp_inv;   // flag as seen with checking enabled
        logic          exp_ovf;
        logic          poke;      // pulse a second start while busy
    } vec_t;

    vec_t vecs [10];

    // Drive one request and check every cycle from acceptance to the
    // cycle after DONE. The caller must be at a negedge with the DUT idle.
    task automatic run_vector(input int idx, input vec_t v);
        logic [AW-1:0] a;
        int            cnt0;
        a = v.base;
        mem[a] = v.h;
        a = v.base + 12'd1;
        mem[a] = v.t;
        a = v.base + 12'd2;
        mem[a] = v.o;
        cnt0 = done_cnt;

        start     = 1'b1;
        base_addr = v.base;
        @(negedge clk);            // cycle N+1
        start     = 1'b0;
        base_addr = 12'h000;
        for (int k = 0; k < 3; k++) begin
            a = v.base + 12'(k);
            check($sformatf("v%0d mem_rd c%0d", idx, k + 1), 32'(mem_rd), 32'd1);
            check($sformatf("v%0d mem_addr c%0d", idx, k + 1), 32'(mem_addr), 32'(a));
            check($sformatf("v%0d busy c%0d", idx, k + 1), 32'(busy), 32'd1);
            check($sformatf("v%0d done c%0d", idx, k + 1), 32'(done), 32'd0);
            if (v.poke && k == 1) begin
                start     = 1'b1;
                base_addr = 12'h123;
            end else begin
                start     = 1'b0;
                base_addr = 12'h000;
            end
            @(negedge clk);
        end
        start = 1'b0;
        // cycle N+4: ones byte on the bus, no strobe
        check($sformatf("v%0d mem_rd c4", idx), 32'(mem_rd), 32'd0);
        check($sformatf("v%0d mem_addr c4", idx), 32'(mem_addr), 32'd0);
        check($sformatf("v%0d done c4", idx), 32'(done), 32'd0);
        @(negedge clk);            // cycle N+5: DONE
        check($sformatf("v%0d done c5", idx), 32'(done), 32'd1);
        check($sformatf("v%0d busy c5", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d value", idx), 32'(value), 32'(v.exp_value));
        check($sformatf("v%0d invalid", idx), 32'(invalid), 32'(v.exp_inv & CHECK_EN));
        check($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.exp_ovf & CHECK_EN));
        @(negedge clk);            // cycle N+6: back in IDLE, result held
        check($sformatf("v%0d done c6", idx), 32'(done), 32'd0);
        check($sformatf("v%0d busy c6", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d value held", idx), 32'(value), 32'(v.exp_value));
        if (v.poke) begin
            repeat (8) @(negedge clk);
            check($sformatf("v%0d done count", idx), 32'(done_cnt - cnt0), 32'd1);
            check($sformatf("v%0d idle after poke", idx), 32'(busy), 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    int cnt_before;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        //          base     h      t      o      value  inv   ovf   poke
        vecs[0] = '{12'h300, 8'd2,  8'd5,  8'd5,  8'd255, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{12'h310, 8'd1,  8'd0,  8'd0,  8'd100, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{12'h320, 8'd0,  8'd9,  8'd9,  8'd99,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{12'h330, 8'd9,  8'd9,  8'd9,  8'hE7,  1'b0, 1'b1, 1'b0};
        vecs[4] = '{12'h340, 8'd0,  8'h0A, 8'd3,  8'd103, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{12'hFFF, 8'd1,  8'd2,  8'd3,  8'd123, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{12'h350, 8'h10, 8'd0,  8'd0,  8'd0,   1'b1, 1'b0, 1'b0};
        vecs[7] = '{12'h360, 8'd2,  8'd5,  8'd6,  8'd0,   1'b0, 1'b1, 1'b0};
        vecs[8] = '{12'h370, 8'd0,  8'd0,  8'd0,  8'd0,   1'b0, 1'b0, 1'b0};
        vecs[9] = '{12'h380, 8'hFF, 8'hFF, 8'hFF, 8'h81,  1'b1, 1'b1, 1'b0};

        // Reset state.
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        check("rst dbg_state", 32'(dbg_state), 32'd0);
        check("rst mem_rd",    32'(mem_rd),    32'd0);
        check("rst mem_addr",  32'(mem_addr),  32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst done",      32'(done),      32'd0);
        check("rst value",     32'(value),     32'd0);
        check("rst invalid",   32'(invalid),   32'd0);
        check("rst overflow",  32'(overflow),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vector(i, vecs[i]);
        end

        // Reset while in RD_T aborts without done or a result update.
        mem[12'h390] = 8'd2;
        mem[12'h391] = 8'd5;
        mem[12'h392] = 8'd5;
        cnt_before = done_cnt;
        start      = 1'b1;
        base_addr  = 12'h390;
        @(negedge clk);            // RD_H
        start = 1'b0;
        check("abort in RD_H", 32'(dbg_state), 32'd1);
        @(negedge clk);            // RD_T
        check("abort in RD_T", 32'(dbg_state), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort dbg_state", 32'(dbg_state), 32'd0);
        check("abort mem_rd",    32'(mem_rd),    32'd0);
        check("abort busy",      32'(busy),      32'd0);
        check("abort value",     32'(value),     32'd0);
        check("abort done",      32'(done),      32'd0);
        repeat (6) @(negedge clk);
        check("abort no done",   32'(done_cnt - cnt_before), 32'd0);
        check("abort still idle", 32'(busy), 32'd0);

        // A following request decodes correctly.
        run_vector(10, '{12'h390, 8'd2, 8'd5, 8'd5, 8'd255, 1'b0, 1'b0, 1'b0});

        // start held high: the next request is taken in the IDLE cycle
        // after DONE, so reads restart 6 cycles after the first strobe.
        start     = 1'b1;
        base_addr = 12'h300;
        repeat (5) @(negedge clk); // N+5
        check("b2b done 1",     32'(done),      32'd1);
        check("b2b value 1",    32'(value),     32'd255);
        @(negedge clk);            // N+6: IDLE
        check("b2b idle state", 32'(dbg_state), 32'd0);
        check("b2b idle busy",  32'(busy),      32'd0);
        check("b2b idle rd",    32'(mem_rd),    32'd0);
        @(negedge clk);            // N+7: second RD_H
        start = 1'b0;
        check("b2b rd again",   32'(mem_rd),    32'd1);
        check("b2b addr again", 32'(mem_addr),  32'h300);
        repeat (4) @(negedge clk); // N+11: second DONE
        check("b2b done 2",     32'(done),      32'd1);
        check("b2b value 2",    32'(value),     32'd255);
        @(negedge clk);
        check("b2b final idle", 32'(busy),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
